// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One full-adder cell with a registered carry; the sum bit is combinational from the current
// operand bits and the stored carry.
module serial_fa_bit (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_cin,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_cout,
  output logic o_carry
);

  logic r_carry;

  assign o_sum   = i_a ^ i_b ^ r_carry;
  assign o_cout  = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);
  assign o_carry = r_carry;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_carry <= i_cin;
    end else if (i_en) begin
      r_carry <= o_cout;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder, LSB first, with valid/ready handshakes on both sides.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_run_en;
  logic               w_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_fa_carry;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Control: state register and next-state decode
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_run_en = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == DONE);

  // Datapath: operand shifters, sum shifter and bit counter
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end else if (w_run_en) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_run_en) begin
      r_sum <= {w_fa_sum, r_sum[WIDTH-1:1]};
      // Wrap to zero on the last bit so the counter never passes WIDTH-1.
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  serial_fa_bit u_fa (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_accept),
    .i_cin   (carry_in),
    .i_en    (w_run_en),
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .o_sum   (w_fa_sum),
    .o_cout  (w_fa_cout),
    .o_carry (w_fa_carry)
  );

  assign sum       = r_sum;
  assign carry_out = w_fa_carry;

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the MSB cycle the stored carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_run_en && w_last) begin
      r_ovf <= w_fa_carry ^ w_fa_cout;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8; checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] low;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = low[W-1] ^ full[W];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accept edge, expected result already queued.
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output bit ok);
    int n;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    n        = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      ok       = 1'b0;
      return;
    end
    tick();
    sb.push_back(model(x, y, c));
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    ok = 1'b1;
  endtask

  task automatic finish_op(input bit chk_lat, input int hold, input bit scramble);
    int           cycles;
    logic [W-1:0] s0;
    logic         c0;
    exp_t         e;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      if (scramble) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    // Counting the accept edge as edge 1, out_valid appears at edge W+1.
    if (chk_lat) chk("latency", cycles, W);
    s0 = sum;
    c0 = carry_out;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, s0);
      chk("hold_cout", carry_out, c0);
      chk("hold_in_ready", in_ready, 0);
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sum", sum, e.s);
      chk("carry_out", carry_out, e.c);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", ovf, e.v);
`endif
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    bit ok;
    int hi;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rstn = 1'b1;
    tick();

    start(8'h01, 8'h01, 1'b0, ok); if (ok) finish_op(1'b1, 0, 1'b0);
    start(8'hFF, 8'h01, 1'b0, ok); if (ok) finish_op(1'b1, 0, 1'b0);
    start(8'h00, 8'h00, 1'b1, ok); if (ok) finish_op(1'b0, 0, 1'b0);
    start(8'h7F, 8'h01, 1'b0, ok); if (ok) finish_op(1'b0, 0, 1'b0);
    start(8'hFF, 8'hFF, 1'b1, ok); if (ok) finish_op(1'b0, 5, 1'b0);
    start(8'h80, 8'h80, 1'b0, ok); if (ok) finish_op(1'b0, 0, 1'b0);
    start(8'h5A, 8'h3C, 1'b0, ok); if (ok) finish_op(1'b1, 0, 1'b1);

    // Back-to-back: next request presented right after the output handshake.
    for (int i = 0; i < 4; i++) begin
      start(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ok);
      if (ok) finish_op(1'b0, i, 1'b0);
    end

    // Reset during the 4th RUN cycle aborts the operation.
    start(8'hA5, 8'h5A, 1'b1, ok);
    tick();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", carry_out, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    rstn = 1'b1;
    sb.delete();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) hi++;
    end
    chk("abort_no_valid", hi, 0);

    // Request held through reset release is taken at the first edge with rstn=1.
    rstn     = 1'b0;
    in_valid = 1'b1;
    a        = 8'h33;
    b        = 8'h44;
    cin      = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    chk("release_accept", busy, 1);
    sb.push_back(model(8'h33, 8'h44, 1'b1));
    in_valid = 1'b0;
    finish_op(1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
